// File: rtl/countdown_pkg.sv
// Shared types, constants and helpers for the mm:ss countdown timer.
package countdown_pkg;

  localparam int unsigned UNIT_W = 6;
  localparam logic [5:0] MAX_UNIT = 6'd59;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} cd_state_t;

  // Saturate a loaded field into the 0..59 range.
  function automatic logic [5:0] clamp59(input logic [5:0] v);
    return (v > MAX_UNIT) ? MAX_UNIT : v;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides RUN cycles down to one count step every DIV enabled cycles.
module tick_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the decrement lands on the same edge the counter wraps.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_mmss.sv
// Loadable mm:ss countdown timer with pause/resume, expiry flag and done pulse.
module countdown_timer_mmss
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic       running,
  output logic       expired,
  output logic       done
);

  cd_state_t state, state_n;
  logic [UNIT_W-1:0] sec_n, min_n;
  logic done_n;
  logic tick;
  logic presc_en, presc_clr;

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      seconds <= '0;
      minutes <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      seconds <= sec_n;
      minutes <= min_n;
      running <= (state_n == RUN);
      expired <= (state_n == EXPIRED);
      done    <= done_n;
    end
  end

  // Priority per cycle: load, then pause, then start.
  always_comb begin
    state_n   = state;
    sec_n     = seconds;
    min_n     = minutes;
    done_n    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    case (state)
      RUN: begin
        if (!pause) begin
          presc_en = 1'b1;
          if (tick) begin
            if (seconds != '0) begin
              sec_n = seconds - 6'd1;
              if (seconds == 6'd1 && minutes == '0) begin
                state_n = EXPIRED;
                done_n  = 1'b1;
              end
            end else if (minutes != '0) begin
              sec_n = MAX_UNIT;
              min_n = minutes - 6'd1;
            end
          end
        end else begin
          state_n = PAUSED;
        end
      end
      default: begin
        if (load) begin
          state_n   = IDLE;
          sec_n     = clamp59(load_sec);
          min_n     = clamp59(load_min);
          presc_clr = 1'b1;
        end else if (!pause && start && state != EXPIRED &&
                     (seconds != '0 || minutes != '0)) begin
          state_n   = RUN;
          presc_clr = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Directed bench: instance a runs at TICK_DIV=1, instance b at TICK_DIV=4.
module tb_countdown_timer_mmss;

  logic clk = 1'b0;
  logic rst;
  logic       a_load, a_start, a_pause;
  logic [5:0] a_lsec, a_lmin, a_sec, a_min;
  logic       a_run, a_exp, a_done;
  logic       b_load, b_start, b_pause;
  logic [5:0] b_lsec, b_lmin, b_sec, b_min;
  logic       b_run, b_exp, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer_mmss #(.TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .load(a_load), .load_sec(a_lsec), .load_min(a_lmin),
    .start(a_start), .pause(a_pause), .seconds(a_sec), .minutes(a_min),
    .running(a_run), .expired(a_exp), .done(a_done)
  );

  countdown_timer_mmss #(.TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .load(b_load), .load_sec(b_lsec), .load_min(b_lmin),
    .start(b_start), .pause(b_pause), .seconds(b_sec), .minutes(b_min),
    .running(b_run), .expired(b_exp), .done(b_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle_inputs();
    a_load = 1'b0; a_start = 1'b0; a_pause = 1'b0;
  endtask

  task automatic b_idle_inputs();
    b_load = 1'b0; b_start = 1'b0; b_pause = 1'b0;
  endtask

  task automatic a_do_load(input logic [5:0] m, input logic [5:0] s, input logic st);
    a_load = 1'b1; a_lmin = m; a_lsec = s; a_start = st;
    step();
    a_idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_idle_inputs(); b_idle_inputs();
    a_lsec = '0; a_lmin = '0; b_lsec = '0; b_lmin = '0;
    step(); step();
    checks++;
    if ({a_min, a_sec, a_run, a_exp, a_done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_a got %0d:%0d r%0b e%0b d%0b want 0:0 r0 e0 d0",
               a_min, a_sec, a_run, a_exp, a_done);
    end
    checks++;
    if ({b_min, b_sec, b_run, b_exp, b_done} !== 15'd0) begin
      errors++;
      $display("FAIL reset_b got %0d:%0d r%0b e%0b d%0b want 0:0 r0 e0 d0",
               b_min, b_sec, b_run, b_exp, b_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_countdown();
    logic [5:0] exp_sec [4];
    exp_sec[0] = 6'd3; exp_sec[1] = 6'd2; exp_sec[2] = 6'd1; exp_sec[3] = 6'd0;
    a_do_load(6'd0, 6'd3, 1'b0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_sec !== exp_sec[i] || a_min !== 6'd0 || a_run !== (i < 3) ||
          a_done !== (i == 3) || a_exp !== (i == 3)) begin
        errors++;
        $display("FAIL basic_%0d got %0d:%0d r%0b e%0b d%0b want 0:%0d r%0b e%0b d%0b",
                 i, a_min, a_sec, a_run, a_exp, a_done, exp_sec[i], i < 3, i == 3, i == 3);
      end
      if (i < 3) step();
    end
    step();
    checks++;
    if (a_done !== 1'b0 || a_exp !== 1'b1 || a_sec !== 6'd0) begin
      errors++;
      $display("FAIL done_drop got d%0b e%0b sec=%0d want d0 e1 sec=0", a_done, a_exp, a_sec);
    end
  endtask

  task automatic test_minute_borrow();
    int dones = 0;
    a_do_load(6'd2, 6'd0, 1'b0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    checks++;
    if (a_min !== 6'd1 || a_sec !== 6'd59) begin
      errors++;
      $display("FAIL borrow got %0d:%0d want 1:59", a_min, a_sec);
    end
    if (a_done) dones++;
    for (int i = 1; i < 120; i++) begin
      step();
      if (a_done) dones++;
    end
    checks++;
    if (a_min !== 6'd0 || a_sec !== 6'd0 || a_done !== 1'b1 || a_exp !== 1'b1) begin
      errors++;
      $display("FAIL two_min_end got %0d:%0d d%0b e%0b want 0:0 d1 e1", a_min, a_sec, a_done, a_exp);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL two_min_pulses got %0d want 1", dones);
    end
  endtask

  task automatic test_clamp_load_priority();
    a_do_load(6'd63, 6'd61, 1'b1);
    checks++;
    if (a_min !== 6'd59 || a_sec !== 6'd59 || a_run !== 1'b0 || a_exp !== 1'b0) begin
      errors++;
      $display("FAIL clamp got %0d:%0d r%0b e%0b want 59:59 r0 e0", a_min, a_sec, a_run, a_exp);
    end
  endtask

  task automatic test_zero_and_expired();
    a_do_load(6'd0, 6'd0, 1'b0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    checks++;
    if (a_run !== 1'b0 || a_done !== 1'b0 || a_exp !== 1'b0) begin
      errors++;
      $display("FAIL zero_start got r%0b d%0b e%0b want r0 d0 e0", a_run, a_done, a_exp);
    end
    a_do_load(6'd0, 6'd1, 1'b0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    checks++;
    if (a_run !== 1'b0 || a_exp !== 1'b1 || a_sec !== 6'd0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL expired_start got r%0b e%0b sec=%0d d%0b want r0 e1 sec=0 d0",
               a_run, a_exp, a_sec, a_done);
    end
    a_do_load(6'd0, 6'd5, 1'b0);
    checks++;
    if (a_exp !== 1'b0 || a_sec !== 6'd5 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL expired_reload got e%0b sec=%0d r%0b want e0 sec=5 r0", a_exp, a_sec, a_run);
    end
  endtask

  task automatic test_rst_and_run_load();
    a_do_load(6'd5, 6'd30, 1'b0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({a_min, a_sec, a_run, a_exp, a_done} !== 15'd0) begin
      errors++;
      $display("FAIL mid_run_rst got %0d:%0d r%0b e%0b d%0b want 0:0 r0 e0 d0",
               a_min, a_sec, a_run, a_exp, a_done);
    end
    a_do_load(6'd5, 6'd30, 1'b0);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    a_do_load(6'd1, 6'd1, 1'b0);
    checks++;
    if (a_min !== 6'd5 || a_sec !== 6'd29 || a_run !== 1'b1) begin
      errors++;
      $display("FAIL run_load got %0d:%0d r%0b want 5:29 r1", a_min, a_sec, a_run);
    end
  endtask

  task automatic test_pause_resume_div4();
    b_load = 1'b1; b_lmin = 6'd0; b_lsec = 6'd10;
    step();
    b_load = 1'b0; b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (b_sec !== ((i < 4) ? 6'd10 : 6'd9) || b_run !== 1'b1) begin
        errors++;
        $display("FAIL div4_run_%0d got sec=%0d r%0b want sec=%0d r1",
                 i, b_sec, b_run, (i < 4) ? 10 : 9);
      end
    end
    b_pause = 1'b1; b_start = 1'b1;
    step();
    b_pause = 1'b0; b_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (b_sec !== 6'd9 || b_run !== 1'b0) begin
        errors++;
        $display("FAIL div4_frozen_%0d got sec=%0d r%0b want sec=9 r0", i, b_sec, b_run);
      end
    end
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step(); step(); step();
    checks++;
    if (b_sec !== 6'd9 || b_run !== 1'b1) begin
      errors++;
      $display("FAIL div4_resume_3 got sec=%0d r%0b want sec=9 r1", b_sec, b_run);
    end
    step();
    checks++;
    if (b_sec !== 6'd8 || b_min !== 6'd0) begin
      errors++;
      $display("FAIL div4_resume_4 got %0d:%0d want 0:8", b_min, b_sec);
    end
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_minute_borrow();
    test_clamp_load_priority();
    test_zero_and_expired();
    test_rst_and_run_load();
    test_pause_resume_div4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
